// File: rtl/spi_target_fifo.sv
// spi_target_fifo
// SPI target endpoint with TX and RX byte FIFOs toward local logic.
// SPICLKIn/SPICSIn/SPIDIn are oversampled in the clk domain through SYNC_STAGES
// flops. Frames of 1..8 bits are shifted in both directions.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   SckMode[1:0]           {CPOL, CPHA}; latched only while IDLE
//   FrameLength[3:0]       bits per frame, 0 or >8 means 8; latched only while IDLE
//   LittleEndian           1: bit0 first on the wire; latched only while IDLE
//   SPICLKIn/SPICSIn/SPIDIn  asynchronous serial inputs (CS active-low)
//   SPIDOut/SPIDOutEn      serial output and its tristate enable
//   TxData/TxValid/TxReady byte stream into the TX FIFO
//   RxData/RxValid/RxReady byte stream out of the RX FIFO (show-ahead head)
//   RxOverrun/TxUnderrun   sticky error flags, cleared by ClearErrors
//
// Handshake: a byte moves on every clk edge where valid and ready are both
// high. Valid never waits for ready. TxReady is high while the TX FIFO is not
// full. RxValid is high while the RX FIFO is not empty, and RxData is then the
// head byte. Both come from registered pointers.

module spi_target_fifo #(
    parameter int DEPTH_LOG2  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] SckMode,
    input  logic [3:0] FrameLength,
    input  logic       LittleEndian,
    input  logic       SPICLKIn,
    input  logic       SPICSIn,
    input  logic       SPIDIn,
    output logic       SPIDOut,
    output logic       SPIDOutEn,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       RxOverrun,
    output logic       TxUnderrun,
    input  logic       ClearErrors
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic logic [7:0] bitrev(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, sdi_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;  // deselected, so reset never looks like a CS fall
            sdi_sync  <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPICLKIn};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPICSIn};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SPIDIn};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // ------------------------------------------------------------------
    // Mode registers. These follow the inputs only while IDLE, so the
    // mode cannot change in the middle of a transfer.
    // ------------------------------------------------------------------
    state_t     state, state_next;
    logic       cpol_q, cpha_q, le_q;
    logic [3:0] fl_q;
    logic [3:0] fl_eff;

    assign fl_eff = (FrameLength == 4'd0 || FrameLength > 4'd8) ? 4'd8 : FrameLength;

    always_ff @(posedge clk) begin
        if (reset) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            le_q   <= 1'b0;
            fl_q   <= 4'd8;
        end else if (state == IDLE) begin
            cpol_q <= SckMode[1];
            cpha_q <= SckMode[0];
            le_q   <= LittleEndian;
            fl_q   <= fl_eff;
        end
    end

    // Leading edge leaves the CPOL idle level.
    logic lead_ev, trail_ev, sample_ev, shift_ev;
    assign lead_ev   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_ev  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_ev = cpha_q ? trail_ev : lead_ev;
    assign shift_ev  = cpha_q ? lead_ev  : trail_ev;

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [7:0]          tx_mem [DEPTH];
    logic [7:0]          rx_mem [DEPTH];
    logic                tx_empty, tx_full, rx_empty, rx_full;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[DEPTH_LOG2] != tx_rp[DEPTH_LOG2]) &&
                      (tx_wp[DEPTH_LOG2-1:0] == tx_rp[DEPTH_LOG2-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[DEPTH_LOG2] != rx_rp[DEPTH_LOG2]) &&
                      (rx_wp[DEPTH_LOG2-1:0] == rx_rp[DEPTH_LOG2-1:0]);

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle datapath commands
    // ------------------------------------------------------------------
    logic [3:0] bit_cnt;
    logic       do_load, do_shift, do_sample, do_abort;

    // A shift event with bit_cnt==0 is a frame boundary. The next byte is
    // loaded instead of shifting. For CPHA=1 this also covers the first
    // frame. For CPHA=0 the first frame is loaded at CS fall instead.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_sample  = 1'b0;
        do_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    do_load    = ~cpha_q;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    do_abort   = 1'b1;
                end else begin
                    if (shift_ev) begin
                        if (bit_cnt == 4'd0) do_load  = 1'b1;
                        else                 do_shift = 1'b1;
                    end
                    do_sample = sample_ev;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift registers, bit counter and frame completion
    // ------------------------------------------------------------------
    logic [7:0] shift_reg, rx_reg, rx_next, rx_aligned, rx_hold;
    logic [3:0] shamt;
    logic       push_pend;

    assign rx_next    = {rx_reg[6:0], sdi_s};
    assign shamt      = 4'd8 - fl_q;
    assign rx_aligned = rx_next << shamt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= 8'hFF;
            rx_reg    <= 8'h00;
            bit_cnt   <= 4'd0;
            rx_hold   <= 8'h00;
            push_pend <= 1'b0;
        end else begin
            state     <= state_next;
            push_pend <= 1'b0;

            if (do_abort) begin
                shift_reg <= 8'hFF;
            end else if (do_load) begin
                if (tx_empty) shift_reg <= 8'hFF;
                else if (le_q) shift_reg <= bitrev(tx_mem[tx_rp[DEPTH_LOG2-1:0]]);
                else shift_reg <= tx_mem[tx_rp[DEPTH_LOG2-1:0]];
            end else if (do_shift) begin
                shift_reg <= {shift_reg[6:0], 1'b1};
            end

            if (do_abort || state == IDLE) begin
                bit_cnt <= 4'd0;
            end else if (do_sample) begin
                rx_reg <= rx_next;
                if (4'(bit_cnt + 4'd1) == fl_q) begin
                    bit_cnt   <= 4'd0;
                    rx_hold   <= le_q ? bitrev(rx_aligned) : rx_aligned;
                    push_pend <= 1'b1;
                end else begin
                    bit_cnt <= 4'(bit_cnt + 4'd1);
                end
            end
        end
    end

    assign SPIDOut   = shift_reg[7];
    assign SPIDOutEn = (state == ACTIVE);

    // ------------------------------------------------------------------
    // FIFO pointers and storage
    // ------------------------------------------------------------------
    logic tx_push, tx_pop, rx_push, rx_pop;
    assign tx_push = TxValid & ~tx_full;
    assign tx_pop  = do_load & ~tx_empty;
    assign rx_push = push_pend & ~rx_full;
    assign rx_pop  = RxReady & ~rx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[DEPTH_LOG2-1:0]] <= TxData;
        if (rx_push) rx_mem[rx_wp[DEPTH_LOG2-1:0]] <= rx_hold;
    end

    assign TxReady = ~tx_full;
    assign RxValid = ~rx_empty;
    assign RxData  = rx_empty ? 8'h00 : rx_mem[rx_rp[DEPTH_LOG2-1:0]];

    // ------------------------------------------------------------------
    // Sticky error flags. A set wins over ClearErrors in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            RxOverrun  <= 1'b0;
            TxUnderrun <= 1'b0;
        end else begin
            if (push_pend & rx_full)     RxOverrun <= 1'b1;
            else if (ClearErrors)        RxOverrun <= 1'b0;
            if (do_load & tx_empty)      TxUnderrun <= 1'b1;
            else if (ClearErrors)        TxUnderrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_target_fifo.sv
// tb_spi_target_fifo
// Directed bench for spi_target_fifo. It drives an SPI controller model on
// the pins and local TX/RX traffic, and checks against hand-computed values.

module tb_spi_target_fifo;

    localparam int H = 8;  // SPI half period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] SckMode;
    logic [3:0] FrameLength;
    logic       LittleEndian;
    logic       SPICLKIn, SPICSIn, SPIDIn;
    logic       SPIDOut, SPIDOutEn;
    logic [7:0] TxData;
    logic       TxValid, TxReady;
    logic [7:0] RxData;
    logic       RxValid, RxReady;
    logic       RxOverrun, TxUnderrun, ClearErrors;

    logic       cpol, cpha;
    int         tests = 0;
    int         fails = 0;

    spi_target_fifo #(.DEPTH_LOG2(3), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .SckMode(SckMode), .FrameLength(FrameLength),
        .LittleEndian(LittleEndian), .SPICLKIn(SPICLKIn), .SPICSIn(SPICSIn),
        .SPIDIn(SPIDIn), .SPIDOut(SPIDOut), .SPIDOutEn(SPIDOutEn),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
        .RxOverrun(RxOverrun), .TxUnderrun(TxUnderrun), .ClearErrors(ClearErrors)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic [1:0] m, input logic [3:0] fl, input logic le);
        SckMode      = m;
        cpol         = m[1];
        cpha         = m[0];
        SPICLKIn     = m[1];
        FrameLength  = fl;
        LittleEndian = le;
        wait_clk(H);
    endtask

    task automatic cs_begin();
        SPICSIn = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_end();
        wait_clk(H);
        SPICSIn = 1'b1;
        wait_clk(2 * H);
    endtask

    // seq holds the bits in wire order: seq[nbits-1] goes first.
    // miso is captured in the same order.
    task automatic spi_frame(input int nbits, input logic [7:0] seq, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                SPIDIn = seq[nbits-1-i];
                wait_clk(H);
                SPICLKIn = ~cpol;
                miso[nbits-1-i] = SPIDOut;
                wait_clk(H);
                SPICLKIn = cpol;
            end else begin
                SPICLKIn = ~cpol;
                SPIDIn   = seq[nbits-1-i];
                wait_clk(H);
                SPICLKIn = cpol;
                miso[nbits-1-i] = SPIDOut;
                wait_clk(H);
            end
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        TxData  = d;
        TxValid = 1'b1;
        wait_clk(1);
        TxValid = 1'b0;
        wait_clk(1);
    endtask

    task automatic pop_rx();
        RxReady = 1'b1;
        wait_clk(1);
        RxReady = 1'b0;
        wait_clk(1);
    endtask

    task automatic clear_errors();
        ClearErrors = 1'b1;
        wait_clk(1);
        ClearErrors = 1'b0;
        wait_clk(1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(2);
        tests++; if (SPIDOutEn !== 1'b0) begin fails++; $display("FAIL reset_douten got %b exp 0", SPIDOutEn); end
        tests++; if (SPIDOut !== 1'b1) begin fails++; $display("FAIL reset_dout got %b exp 1", SPIDOut); end
        tests++; if (TxReady !== 1'b1) begin fails++; $display("FAIL reset_txready got %b exp 1", TxReady); end
        tests++; if (RxValid !== 1'b0) begin fails++; $display("FAIL reset_rxvalid got %b exp 0", RxValid); end
        tests++; if (RxData !== 8'h00) begin fails++; $display("FAIL reset_rxdata got %h exp 00", RxData); end
        tests++; if (RxOverrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b exp 0", RxOverrun); end
        tests++; if (TxUnderrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b exp 0", TxUnderrun); end
    endtask

    task automatic test_mode0_msb();
        logic [7:0] miso;
        set_mode(2'b00, 4'd8, 1'b0);
        push_tx(8'hA5);
        cs_begin();
        tests++; if (SPIDOutEn !== 1'b1) begin fails++; $display("FAIL m0_douten got %b exp 1", SPIDOutEn); end
        spi_frame(8, 8'h3C, miso);
        cs_end();
        tests++; if (miso !== 8'hA5) begin fails++; $display("FAIL m0_miso got %h exp a5", miso); end
        tests++; if (RxValid !== 1'b1) begin fails++; $display("FAIL m0_rxvalid got %b exp 1", RxValid); end
        tests++; if (RxData !== 8'h3C) begin fails++; $display("FAIL m0_rxdata got %h exp 3c", RxData); end
        tests++; if (SPIDOutEn !== 1'b0) begin fails++; $display("FAIL m0_douten_off got %b exp 0", SPIDOutEn); end
        pop_rx();
        tests++; if (RxValid !== 1'b0) begin fails++; $display("FAIL m0_rx_drained got %b exp 0", RxValid); end
    endtask

    task automatic test_mode3_lsb_fl5();
        logic [7:0] miso;
        clear_errors();
        set_mode(2'b11, 4'd5, 1'b1);
        push_tx(8'h13);
        cs_begin();
        spi_frame(5, 8'b0001_0110, miso);
        cs_end();
        tests++; if (miso !== 8'b0001_1001) begin fails++; $display("FAIL m3_miso got %b exp 00011001", miso); end
        tests++; if (RxData !== 8'h0D) begin fails++; $display("FAIL m3_rxdata got %h exp 0d", RxData); end
        tests++; if (TxUnderrun !== 1'b0) begin fails++; $display("FAIL m3_underrun got %b exp 0", TxUnderrun); end
        pop_rx();
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2;
        set_mode(2'b00, 4'd8, 1'b0);
        push_tx(8'h81);
        push_tx(8'h7E);
        cs_begin();
        spi_frame(8, 8'h42, m1);
        spi_frame(8, 8'hBD, m2);
        cs_end();
        tests++; if (m1 !== 8'h81) begin fails++; $display("FAIL b2b_miso1 got %h exp 81", m1); end
        tests++; if (m2 !== 8'h7E) begin fails++; $display("FAIL b2b_miso2 got %h exp 7e", m2); end
        tests++; if (RxData !== 8'h42) begin fails++; $display("FAIL b2b_rx1 got %h exp 42", RxData); end
        pop_rx();
        tests++; if (RxData !== 8'hBD) begin fails++; $display("FAIL b2b_rx2 got %h exp bd", RxData); end
        pop_rx();
        tests++; if (RxValid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b exp 0", RxValid); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] miso;
        logic [7:0] exp_b;
        set_mode(2'b00, 4'd8, 1'b0);
        clear_errors();
        for (int k = 1; k <= 8; k++) begin
            cs_begin();
            spi_frame(8, 8'(8'h10 + k), miso);
            cs_end();
        end
        tests++; if (RxOverrun !== 1'b0) begin fails++; $display("FAIL ovr_before got %b exp 0", RxOverrun); end
        cs_begin();
        spi_frame(8, 8'h99, miso);
        cs_end();
        tests++; if (RxOverrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b exp 1", RxOverrun); end
        tests++; if (RxData !== 8'h11) begin fails++; $display("FAIL ovr_head got %h exp 11", RxData); end
        for (int k = 1; k <= 8; k++) begin
            exp_b = 8'(8'h10 + k);
            tests++; if (RxValid !== 1'b1 || RxData !== exp_b) begin
                fails++; $display("FAIL ovr_drain%0d got v=%b d=%h exp v=1 d=%h", k, RxValid, RxData, exp_b);
            end
            pop_rx();
        end
        tests++; if (RxValid !== 1'b0) begin fails++; $display("FAIL ovr_empty got %b exp 0", RxValid); end
    endtask

    task automatic test_underrun();
        logic [7:0] miso;
        set_mode(2'b00, 4'd8, 1'b0);
        clear_errors();
        tests++; if (RxOverrun !== 1'b0 || TxUnderrun !== 1'b0) begin
            fails++; $display("FAIL clr_flags got ovr=%b und=%b exp 0 0", RxOverrun, TxUnderrun);
        end
        cs_begin();
        spi_frame(8, 8'h00, miso);
        cs_end();
        tests++; if (miso !== 8'hFF) begin fails++; $display("FAIL und_miso got %h exp ff", miso); end
        tests++; if (TxUnderrun !== 1'b1) begin fails++; $display("FAIL und_flag got %b exp 1", TxUnderrun); end
        tests++; if (RxValid !== 1'b1) begin fails++; $display("FAIL und_rxvalid got %b exp 1", RxValid); end
        pop_rx();
        clear_errors();
        tests++; if (TxUnderrun !== 1'b0) begin fails++; $display("FAIL und_clear got %b exp 0", TxUnderrun); end
    endtask

    task automatic test_cs_abort();
        logic [7:0] miso;
        set_mode(2'b00, 4'd8, 1'b0);
        cs_begin();
        spi_frame(3, 8'b0000_0101, miso);
        cs_end();
        tests++; if (SPIDOutEn !== 1'b0) begin fails++; $display("FAIL abort_douten got %b exp 0", SPIDOutEn); end
        tests++; if (RxValid !== 1'b0) begin fails++; $display("FAIL abort_nopush got %b exp 0", RxValid); end
        push_tx(8'hC3);
        cs_begin();
        spi_frame(8, 8'h96, miso);
        cs_end();
        tests++; if (miso !== 8'hC3) begin fails++; $display("FAIL abort_next_miso got %h exp c3", miso); end
        tests++; if (RxValid !== 1'b1 || RxData !== 8'h96) begin
            fails++; $display("FAIL abort_next_rx got v=%b d=%h exp v=1 d=96", RxValid, RxData);
        end
        pop_rx();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset        = 1'b1;
        SckMode      = 2'b00;
        FrameLength  = 4'd8;
        LittleEndian = 1'b0;
        SPICLKIn     = 1'b0;
        SPICSIn      = 1'b1;
        SPIDIn       = 1'b0;
        TxData       = 8'h00;
        TxValid      = 1'b0;
        RxReady      = 1'b0;
        ClearErrors  = 1'b0;
        cpol         = 1'b0;
        cpha         = 1'b0;

        test_reset();
        test_mode0_msb();
        test_mode3_lsb_fl5();
        test_back_to_back();
        test_rx_overrun();
        test_underrun();
        test_cs_abort();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
